dmem_utlb: RTL and testbench

- Multi-entry data-side micro-TLB between the execute stage's address path and the shared main TLB.
- Generalises the single-entry query cache into ENTRIES fully-associative entries with replacement, flush, abort-on-flush and hit/miss counters.
- Caches positive and negative translation results, so TLB exceptions are also served from the micro-TLB.

---
 rtl/dmem_utlb_pkg.sv | 20 ++
 rtl/dmem_utlb_entry.sv | 60 ++++++
 rtl/dmem_utlb.sv | 218 +++++++++++++++++++++
 tb/tb_dmem_utlb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_utlb_pkg.sv
// rtl/dmem_utlb_pkg.sv - shared constants and FSM encoding for the data-side micro-TLB
//
// Purpose: segment constant for the unmapped kseg0/kseg1 window, page-offset
// width, and the state encoding of the micro-TLB query FSM.
// Ports: none (package).
package dmem_utlb_pkg;

  // req_vaddr[31:30] equal to this value is kseg0/kseg1: unmapped, no lookup.
  localparam logic [1:0] KSEG01 = 2'b10;

  // 4 KB pages.
  localparam int PAGE_OFF_W = 12;

  typedef enum logic [1:0] {
    UTLB_IDLE  = 2'd0,
    UTLB_QUERY = 2'd1,
    UTLB_FILL  = 2'd2
  } utlb_state_t;

endpackage

// File: rtl/dmem_utlb_entry.sv
// rtl/dmem_utlb_entry.sv - one fully-associative micro-TLB entry with match output
//
// Purpose: holds valid/vpn/pfn/miss/invalid/dirty for one translation and
// compares the stored vpn with the lookup vpn.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   clr              invalidate this entry at the next edge (wins over wr_en)
//   wr_en            load the wr_* fields and mark the entry valid
//   wr_vpn/wr_pfn    page numbers to store
//   wr_miss/wr_invalid/wr_dirty  cached main-TLB status
//   lookup_vpn       vpn of the current request
//   valid, match     entry state and hit indication
//   pfn, miss, invalid, dirty  stored fields
module utlb_entry #(
  parameter int VPN_W = 20,
  parameter int PFN_W = 20
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [VPN_W-1:0] wr_vpn,
  input  logic [PFN_W-1:0] wr_pfn,
  input  logic             wr_miss,
  input  logic             wr_invalid,
  input  logic             wr_dirty,
  input  logic [VPN_W-1:0] lookup_vpn,
  output logic             valid,
  output logic             match,
  output logic [PFN_W-1:0] pfn,
  output logic             miss,
  output logic             invalid,
  output logic             dirty
);

  logic [VPN_W-1:0] vpn;

  // A flush in the same cycle as the fill leaves the entry invalid.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
    end
  end

  // Payload fields need no reset; they are only observed while valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      vpn     <= wr_vpn;
      pfn     <= wr_pfn;
      miss    <= wr_miss;
      invalid <= wr_invalid;
      dirty   <= wr_dirty;
    end
  end

  assign match = valid && (vpn == lookup_vpn);

endmodule

// File: rtl/dmem_utlb.sv
// rtl/dmem_utlb.sv - multi-entry data-side micro-TLB in front of the shared main TLB
//
// Purpose: serves data-address translations (and cached TLB exceptions) from
// ENTRIES fully-associative entries; on a miss queries the main TLB over a
// registered address and fills a victim entry.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   req_valid/req_vaddr/req_write  lookup request (held until resp_valid)
//   resp_valid/resp_paddr       translation result, combinational from IDLE
//   resp_refill/resp_invalid/resp_mod  exception flags
//   busy                        FSM not in IDLE
//   tlb_vaddr                   registered page address to the main TLB
//   tlb_paddr/tlb_miss/tlb_invalid/tlb_dirty  main TLB result
//   flush                       invalidate all entries
//   hit_cnt/miss_cnt            served-lookup and main-TLB-query counters
module dmem_utlb
  import dmem_utlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int VPN_W   = 20,
  parameter int PFN_W   = 20,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  input  logic [31:0]      req_vaddr,
  input  logic             req_write,
  output logic             resp_valid,
  output logic [31:0]      resp_paddr,
  output logic             resp_refill,
  output logic             resp_invalid,
  output logic             resp_mod,
  output logic             busy,
  output logic [31:0]      tlb_vaddr,
  input  logic [31:0]      tlb_paddr,
  input  logic             tlb_miss,
  input  logic             tlb_invalid,
  input  logic             tlb_dirty,
  input  logic             flush,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  utlb_state_t state, state_nxt;

  logic [VPN_W-1:0]   req_vpn;
  logic [ENTRIES-1:0] ent_valid, ent_match, ent_wr;
  logic [ENTRIES-1:0] ent_miss, ent_invalid, ent_dirty;
  logic [PFN_W-1:0]   ent_pfn [ENTRIES];

  logic               bypass;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               has_free;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   victim;
  logic [IDX_W-1:0]   rr_ptr;
  logic               query_start;
  logic               fill_wr;

  // Low page-offset bits of the main-TLB result are not part of the frame.
  logic               unused_tlb_paddr;
  assign unused_tlb_paddr = &{1'b0, tlb_paddr[31-PFN_W:0]};

  assign req_vpn = req_vaddr[31 -: VPN_W];
  assign bypass  = req_valid && (req_vaddr[31:30] == KSEG01);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    utlb_entry #(
      .VPN_W (VPN_W),
      .PFN_W (PFN_W)
    ) u_entry (
      .clk        (clk),
      .resetn     (resetn),
      .clr        (flush),
      .wr_en      (ent_wr[g]),
      .wr_vpn     (tlb_vaddr[31 -: VPN_W]),
      .wr_pfn     (tlb_paddr[31 -: PFN_W]),
      .wr_miss    (tlb_miss),
      .wr_invalid (tlb_invalid),
      .wr_dirty   (tlb_dirty),
      .lookup_vpn (req_vpn),
      .valid      (ent_valid[g]),
      .match      (ent_match[g]),
      .pfn        (ent_pfn[g]),
      .miss       (ent_miss[g]),
      .invalid    (ent_invalid[g]),
      .dirty      (ent_dirty[g])
    );
  end

  // Scan from the top so the lowest index wins. The fill path never creates
  // duplicate vpns, so the priority only matters to keep the mux well defined.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Victim: lowest-index free slot, otherwise the round-robin pointer.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    victim = has_free ? free_idx : rr_ptr;
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_wr[i] = fill_wr && (victim == IDX_W'(i));
    end
  end

  // Responses only come out of IDLE; QUERY and FILL are silent.
  always_comb begin
    resp_valid   = 1'b0;
    resp_paddr   = req_vaddr;
    resp_refill  = 1'b0;
    resp_invalid = 1'b0;
    resp_mod     = 1'b0;
    if (state == UTLB_IDLE && req_valid) begin
      if (bypass) begin
        resp_valid = 1'b1;
      end else if (hit) begin
        resp_valid   = 1'b1;
        resp_paddr   = {ent_pfn[hit_idx], req_vaddr[PAGE_OFF_W-1:0]};
        resp_refill  = ent_miss[hit_idx];
        resp_invalid = ent_invalid[hit_idx] && !ent_miss[hit_idx];
        resp_mod     = req_write && !ent_miss[hit_idx] &&
                       !ent_invalid[hit_idx] && !ent_dirty[hit_idx];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    query_start = 1'b0;
    fill_wr     = 1'b0;
    case (state)
      UTLB_IDLE: begin
        if (req_valid && !bypass && !hit && !flush) begin
          query_start = 1'b1;
          state_nxt   = UTLB_QUERY;
        end
      end
      UTLB_QUERY: begin
        // A flush here discards the main-TLB answer; IDLE re-queries.
        if (flush) begin
          state_nxt = UTLB_IDLE;
        end else begin
          fill_wr   = 1'b1;
          state_nxt = UTLB_FILL;
        end
      end
      UTLB_FILL: begin
        state_nxt = UTLB_IDLE;
      end
      default: begin
        state_nxt = UTLB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= UTLB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tlb_vaddr <= '0;
    end else if (query_start) begin
      tlb_vaddr <= {req_vaddr[31:PAGE_OFF_W], {PAGE_OFF_W{1'b0}}};
    end
  end

  // The pointer only moves when it actually chose the victim.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (fill_wr && !has_free) begin
      rr_ptr <= rr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (resp_valid) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
      if (query_start) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

  assign busy = (state != UTLB_IDLE);

endmodule

// File: tb/tb_dmem_utlb.sv
// tb/tb_dmem_utlb.sv - directed self-checking bench for dmem_utlb
module tb_dmem_utlb;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_vaddr = '0;
  logic        req_write = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        resp_refill, resp_invalid, resp_mod;
  logic        busy;
  logic [31:0] tlb_vaddr;
  logic [31:0] tlb_paddr = '0;
  logic        tlb_miss = 1'b0;
  logic        tlb_invalid = 1'b0;
  logic        tlb_dirty = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hit_cnt, miss_cnt;

  int checks = 0;
  int failures = 0;

  int          lat;
  logic [31:0] pa;
  logic [2:0]  fl;

  always #5 clk = ~clk;

  dmem_utlb #(.ENTRIES(4), .VPN_W(20), .PFN_W(20), .CNT_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_vaddr    (req_vaddr),
    .req_write    (req_write),
    .resp_valid   (resp_valid),
    .resp_paddr   (resp_paddr),
    .resp_refill  (resp_refill),
    .resp_invalid (resp_invalid),
    .resp_mod     (resp_mod),
    .busy         (busy),
    .tlb_vaddr    (tlb_vaddr),
    .tlb_paddr    (tlb_paddr),
    .tlb_miss     (tlb_miss),
    .tlb_invalid  (tlb_invalid),
    .tlb_dirty    (tlb_dirty),
    .flush        (flush),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tlb(input logic [31:0] p, input logic m, input logic i, input logic d);
    tlb_paddr = p; tlb_miss = m; tlb_invalid = i; tlb_dirty = d;
  endtask

  // Called at posedge+1; returns edges until resp_valid, the sampled result,
  // and leaves the bench one cycle after the response with req_valid low.
  task automatic lookup(input logic [31:0] a, input logic w,
                        output int l, output logic [31:0] p, output logic [2:0] f);
    req_vaddr = a; req_write = w; req_valid = 1'b1; l = 0;
    #1;
    while (!resp_valid && l < 10) begin
      step();
      l++;
    end
    p = resp_paddr;
    f = {resp_refill, resp_invalid, resp_mod};
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    step();
    step();
    resetn = 1'b1;
    #1;
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hit_cnt", hit_cnt, 32'd0);
    chk("reset_miss_cnt", miss_cnt, 32'd0);
    chk("reset_tlb_vaddr", tlb_vaddr, 32'd0);
    step();

    // Bypass through kseg0/1.
    lookup(32'h8000_1234, 1'b1, lat, pa, fl);
    chk("byp_lat", 32'(lat), 32'd0);
    chk("byp_paddr", pa, 32'h8000_1234);
    chk("byp_flags", 32'(fl), 32'd0);
    chk("byp_hit_cnt", hit_cnt, 32'd1);
    chk("byp_miss_cnt", miss_cnt, 32'd0);

    // Miss then hit on the same page.
    set_tlb(32'h1F00_0000, 1'b0, 1'b0, 1'b1);
    lookup(32'h0040_0010, 1'b0, lat, pa, fl);
    chk("miss_lat", 32'(lat), 32'd3);
    chk("miss_paddr", pa, 32'h1F00_0010);
    chk("miss_flags", 32'(fl), 32'd0);
    chk("miss_tlb_vaddr", tlb_vaddr, 32'h0040_0000);
    lookup(32'h0040_0FFC, 1'b0, lat, pa, fl);
    chk("hit_lat", 32'(lat), 32'd0);
    chk("hit_paddr", pa, 32'h1F00_0FFC);
    chk("hit_miss_cnt", miss_cnt, 32'd1);
    chk("hit_hit_cnt", hit_cnt, 32'd3);

    // Negative caching of a refill exception.
    set_tlb(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    lookup(32'h0001_2000, 1'b0, lat, pa, fl);
    chk("neg_lat", 32'(lat), 32'd3);
    chk("neg_flags", 32'(fl), 32'b100);
    lookup(32'h0001_2000, 1'b0, lat, pa, fl);
    chk("neg_rep_lat", 32'(lat), 32'd0);
    chk("neg_rep_flags", 32'(fl), 32'b100);
    chk("neg_miss_cnt", miss_cnt, 32'd2);

    // Clean page: load no flag, store raises mod.
    set_tlb(32'h2A00_0000, 1'b0, 1'b0, 1'b0);
    lookup(32'h0003_0000, 1'b0, lat, pa, fl);
    chk("clean_ld_lat", 32'(lat), 32'd3);
    chk("clean_ld_flags", 32'(fl), 32'd0);
    chk("clean_ld_paddr", pa, 32'h2A00_0000);
    lookup(32'h0003_0004, 1'b1, lat, pa, fl);
    chk("clean_st_lat", 32'(lat), 32'd0);
    chk("clean_st_flags", 32'(fl), 32'b001);

    // Invalid page: invalid flag, mod suppressed on store.
    set_tlb(32'h3000_0000, 1'b0, 1'b1, 1'b0);
    lookup(32'h0005_0000, 1'b0, lat, pa, fl);
    chk("inv_lat", 32'(lat), 32'd3);
    chk("inv_flags", 32'(fl), 32'b010);
    lookup(32'h0005_0008, 1'b1, lat, pa, fl);
    chk("inv_st_flags", 32'(fl), 32'b010);
    chk("inv_miss_cnt", miss_cnt, 32'd4);
    chk("inv_hit_cnt", hit_cnt, 32'd9);

    // Replacement: slots hold 0x400,0x12,0x30,0x50; rr_ptr=0.
    set_tlb(32'h3300_0000, 1'b0, 1'b0, 1'b1);
    lookup(32'h0006_0000, 1'b0, lat, pa, fl);
    chk("rep_new_lat", 32'(lat), 32'd3);
    lookup(32'h0006_0010, 1'b0, lat, pa, fl);
    chk("rep_new_hit_lat", 32'(lat), 32'd0);
    chk("rep_new_hit_paddr", pa, 32'h3300_0010);
    lookup(32'h0040_0010, 1'b0, lat, pa, fl);
    chk("rep_evicted_lat", 32'(lat), 32'd3);
    lookup(32'h0001_2000, 1'b0, lat, pa, fl);
    chk("rep_second_evict_lat", 32'(lat), 32'd3);
    chk("rep_second_evict_flags", 32'(fl), 32'd0);
    lookup(32'h0005_0000, 1'b0, lat, pa, fl);
    chk("rep_survivor_lat", 32'(lat), 32'd0);
    chk("rep_survivor_flags", 32'(fl), 32'b010);
    chk("rep_miss_cnt", miss_cnt, 32'd7);
    chk("rep_hit_cnt", hit_cnt, 32'd14);

    // Flush during QUERY: nothing written, request re-queries.
    set_tlb(32'h5500_0000, 1'b0, 1'b0, 1'b1);
    req_vaddr = 32'h0007_0000; req_write = 1'b0; req_valid = 1'b1;
    #1;
    chk("fq_idle_resp", 32'(resp_valid), 32'd0);
    step();
    chk("fq_query_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("fq_back_idle", 32'(busy), 32'd0);
    chk("fq_no_resp", 32'(resp_valid), 32'd0);
    chk("fq_miss_cnt", miss_cnt, 32'd8);
    lat = 0;
    while (!resp_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("fq_requery_lat", 32'(lat), 32'd3);
    chk("fq_requery_paddr", resp_paddr, 32'h5500_0000);
    step();
    req_valid = 1'b0;
    chk("fq_miss_cnt2", miss_cnt, 32'd9);
    chk("fq_hit_cnt", hit_cnt, 32'd15);

    // Flush alone: earlier pages miss, counters unaffected.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_hit_cnt", hit_cnt, 32'd15);
    chk("fl_miss_cnt", miss_cnt, 32'd9);
    lookup(32'h0007_0000, 1'b0, lat, pa, fl);
    chk("fl_page70_lat", 32'(lat), 32'd3);
    lookup(32'h0005_0000, 1'b0, lat, pa, fl);
    chk("fl_page50_lat", 32'(lat), 32'd3);
    chk("fl_miss_cnt2", miss_cnt, 32'd11);

    // Flush during FILL wins over the write just made.
    req_vaddr = 32'h0009_0000; req_valid = 1'b1;
    step();
    step();
    chk("ff_fill_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    lookup(32'h0009_0000, 1'b0, lat, pa, fl);
    chk("ff_refetch_lat", 32'(lat), 32'd3);

    // Reset mid-query.
    req_vaddr = 32'h000A_0000; req_valid = 1'b1;
    step();
    chk("rq_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    req_valid = 1'b0;
    step();
    resetn = 1'b1;
    chk("rq_busy_after", 32'(busy), 32'd0);
    chk("rq_hit_cnt", hit_cnt, 32'd0);
    chk("rq_miss_cnt", miss_cnt, 32'd0);
    chk("rq_tlb_vaddr", tlb_vaddr, 32'd0);
    lookup(32'h0007_0000, 1'b0, lat, pa, fl);
    chk("rq_entries_cleared_lat", 32'(lat), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
